// File: rtl/seq_det_sched_pkg.sv
// Shared state encoding and default parameters for the sequence-detector scheduler.
// The optional SEQ_DET_SCHED_FIXED_PRIO_EN build macro is consumed by the top module.
package seq_det_sched_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_GRANT  = 2'b01;
    localparam logic [1:0] ST_STREAM = 2'b10;
    localparam logic [1:0] ST_REPORT = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        GRANT  = ST_GRANT,
        STREAM = ST_STREAM,
        REPORT = ST_REPORT
    } state_e;

    localparam int N_REQ_DEF   = 4;
    localparam int LEN_W_DEF   = 8;
    localparam int CNT_W_DEF   = 8;
    localparam int RUN_LEN_DEF = 2;

endpackage

// File: rtl/seq_det_sched_run_detector.sv
// Consecutive-ones run detector: saturating run count, registered run flag z and a
// combinational hit strobe for the bit being consumed this cycle.
module run_detector #(
    parameter int RUN_LEN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_i,
    input  logic bit_en,
    output logic hit,
    output logic z
);

    localparam int R_W = $clog2(RUN_LEN + 1);

    logic [R_W-1:0] r_q, r_d;
    logic           z_q, z_d;

    always_comb begin
        r_d = r_q;
        hit = 1'b0;
        if (clr) begin
            r_d = '0;
        end else if (bit_en) begin
            if (bit_i) begin
                // Overlapping runs: every further 1 after the threshold is another hit.
                hit = (r_q >= R_W'(RUN_LEN - 1));
                if (r_q != R_W'(RUN_LEN)) r_d = r_q + 1'b1;
            end else begin
                r_d = '0;
            end
        end
        z_d = (r_d == R_W'(RUN_LEN));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
            z_q <= 1'b0;
        end else begin
            r_q <= r_d;
            z_q <= z_d;
        end
    end

    assign z = z_q;

endmodule

// File: rtl/seq_det_sched.sv
// Scheduler sharing one run detector among N_REQ bit-serial sources (round-robin by default,
// fixed lowest-index priority when SEQ_DET_SCHED_FIXED_PRIO_EN is defined).
module seq_det_sched
    import seq_det_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int RUN_LEN = RUN_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*LEN_W-1:0]   frame_len,
    input  logic [N_REQ-1:0]         bit_in,
    output logic [N_REQ-1:0]         grant,
    output logic                     bit_rdy,
    output logic                     z,
    output logic                     done,
    output logic                     aborted,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output logic [CNT_W-1:0]         hit_cnt
);

    localparam int ID_W = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  sel_q, sel_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             bit_rdy_q, bit_rdy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic [ID_W-1:0]  done_id_q, done_id_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    logic [ID_W-1:0]  pick;
    logic             det_clr, det_en, det_hit;

    always_comb begin
        pick = '0;
`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) pick = ID_W'(i);
        end
`else
        begin
            logic found;
            found = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                int idx;
                idx = (int'(ptr_q) + i) % N_REQ;
                if (!found && req[idx]) begin
                    found = 1'b1;
                    pick  = ID_W'(idx);
                end
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        bit_rdy_d = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        done_id_d = '0;
        hit_cnt_d = '0;
        det_clr   = 1'b0;
        det_en    = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (|req) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    grant_d = N_REQ'(1) << pick;
                end
            end
            GRANT: begin
                det_clr = 1'b1;
                cnt_d   = '0;
                rem_d   = frame_len[int'(sel_q)*LEN_W +: LEN_W];
                if (rem_d == '0) begin
                    state_d   = REPORT;
                    done_d    = 1'b1;
                    done_id_d = sel_q;
                end else begin
                    state_d   = STREAM;
                    bit_rdy_d = 1'b1;
                end
            end
            STREAM: begin
                // A dropped request ends the frame without consuming this cycle's bit.
                if (!req[sel_q]) begin
                    state_d   = REPORT;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    done_id_d = sel_q;
                    hit_cnt_d = cnt_q;
                end else begin
                    det_en = 1'b1;
                    if (det_hit && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d   = REPORT;
                        done_d    = 1'b1;
                        done_id_d = sel_q;
                        hit_cnt_d = cnt_d;
                    end else begin
                        rem_d     = rem_q - 1'b1;
                        bit_rdy_d = 1'b1;
                    end
                end
            end
            REPORT: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = (int'(sel_q) == N_REQ - 1) ? '0 : sel_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            ptr_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            bit_rdy_q <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            done_id_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            bit_rdy_q <= bit_rdy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            done_id_q <= done_id_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    run_detector #(
        .RUN_LEN(RUN_LEN)
    ) u_det (
        .clk    (clk),
        .rst    (rst),
        .clr    (det_clr),
        .bit_i  (bit_in[sel_q]),
        .bit_en (det_en),
        .hit    (det_hit),
        .z      (z)
    );

    assign grant   = grant_q;
    assign bit_rdy = bit_rdy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign done_id = done_id_q;
    assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed and randomized checks of seq_det_sched; completed frames are matched against a
// queue of expected {aborted, done_id, hit_cnt} results.
module tb_seq_det_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] frame_len;
  logic [3:0]  bit_in;
  logic [3:0]  grant;
  logic        bit_rdy, z, done, aborted;
  logic [1:0]  done_id;
  logic [7:0]  hit_cnt;

  logic [3:0]  req2;
  logic [31:0] frame_len2;
  logic [3:0]  bit_in2;
  logic [3:0]  grant2;
  logic        bit_rdy2, z2, done2, aborted2;
  logic [1:0]  done_id2;
  logic [1:0]  hit_cnt2;

  logic [10:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  seq_det_sched dut (
    .clk(clk), .rst(rst), .req(req), .frame_len(frame_len), .bit_in(bit_in),
    .grant(grant), .bit_rdy(bit_rdy), .z(z), .done(done), .aborted(aborted),
    .done_id(done_id), .hit_cnt(hit_cnt)
  );

  seq_det_sched #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req(req2), .frame_len(frame_len2), .bit_in(bit_in2),
    .grant(grant2), .bit_rdy(bit_rdy2), .z(z2), .done(done2), .aborted(aborted2),
    .done_id(done_id2), .hit_cnt(hit_cnt2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_hits(input logic [31:0] pattern, input int len);
    int r, h;
    r = 0;
    h = 0;
    for (int k = 0; k < len; k++) begin
      if (pattern[k]) begin
        if (r >= 1) h++;
        if (r < 2) r++;
      end else begin
        r = 0;
      end
    end
    return h;
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL sb_unexpected_done observed id=%0d cnt=%0d expected no done", done_id, hit_cnt);
      end else begin
        chk("sb_result", {21'd0, aborted, done_id, hit_cnt}, {21'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    bit_in = '0;
    req2 = '0;
    bit_in2 = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // driver: one complete frame from a single source
  task automatic do_frame(input int src, input int len, input logic [31:0] pattern, input int hits);
    req[src] = 1'b1;
    frame_len[src*8 +: 8] = 8'(len);
    exp_q.push_back({1'b0, 2'(src), 8'(hits)});
    tick();
    chk("frame_grant", {28'd0, grant}, 32'd1 << src);
    chk("frame_grant_no_done", {31'd0, done}, 32'd0);
    for (int k = 0; k < len; k++) begin
      tick();
      bit_in[src] = pattern[k];
      chk("frame_bit_rdy", {31'd0, bit_rdy}, 32'd1);
    end
    tick();
    chk("frame_done", {31'd0, done}, 32'd1);
    chk("frame_report_bit_rdy", {31'd0, bit_rdy}, 32'd0);
    req[src] = 1'b0;
    bit_in[src] = 1'b0;
    tick();
    chk("frame_idle_grant", {28'd0, grant}, 32'd0);
    chk("frame_idle_done", {31'd0, done}, 32'd0);
  endtask

  task automatic wait_grant(input string tag);
    int c;
    c = 0;
    while (grant === 4'd0 && c < 20) begin
      tick();
      c++;
    end
    if (c >= 20) chk({tag, "_grant_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    if (c >= 40) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] pat;
    int          src, len, second_id;
    n_checks = 0;
    n_fail = 0;
    frame_len = '0;
    frame_len2 = '0;
    do_reset();

    chk("reset_grant", {28'd0, grant}, 32'd0);
    chk("reset_outputs", {28'd0, bit_rdy, z, done, aborted}, 32'd0);
    chk("reset_id_cnt", {22'd0, done_id, hit_cnt}, 32'd0);

    // bits 0,1,1,1,0,1 -> two hits, done 8 cycles after req
    do_frame(0, 6, 32'b101110, 2);

    // all four requesting, len 1 each: served in index order
    do_reset();
    req = 4'b1111;
    frame_len = {8'd1, 8'd1, 8'd1, 8'd1};
    bit_in = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back({1'b0, 2'(s), 8'd0});
      wait_grant("rr");
      chk("rr_grant_order", {28'd0, grant}, 32'd1 << s);
      wait_done("rr");
      req[s] = 1'b0;
      tick();
    end
    bit_in = '0;

    // zero-length frame
    exp_q.push_back({1'b0, 2'd2, 8'd0});
    req = 4'b0100;
    frame_len[16 +: 8] = 8'd0;
    tick();
    chk("len0_grant", {28'd0, grant}, 32'h4);
    chk("len0_grant_bit_rdy", {31'd0, bit_rdy}, 32'd0);
    tick();
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_report_bit_rdy", {31'd0, bit_rdy}, 32'd0);
    req = '0;
    tick();

    // hit counter saturation on the CNT_W=2 instance
    req2 = 4'b0001;
    frame_len2[7:0] = 8'd8;
    bit_in2 = 4'b0001;
    tick();
    chk("sat_grant", {28'd0, grant2}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 6) chk("sat_z_late_stream", {31'd0, z2}, 32'd1);
    end
    chk("sat_z_last_stream", {31'd0, z2}, 32'd1);
    tick();
    chk("sat_done", {31'd0, done2}, 32'd1);
    chk("sat_hit_cnt", {30'd0, hit_cnt2}, 32'd3);
    req2 = '0;
    bit_in2 = '0;
    tick();

    // request drop after 3 bits of a 10-bit frame
    exp_q.push_back({1'b1, 2'd1, 8'd2});
    req = 4'b0010;
    frame_len[8 +: 8] = 8'd10;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      bit_in[1] = 1'b1;
    end
    tick();
    req[1] = 1'b0;
    tick();
    chk("abort_done", {31'd0, done}, 32'd1);
    chk("abort_flag", {31'd0, aborted}, 32'd1);
    bit_in = '0;
    tick();
    chk("abort_idle_aborted", {31'd0, aborted}, 32'd0);

    // reset in the middle of a stream
    req = 4'b1000;
    frame_len[24 +: 8] = 8'd10;
    bit_in[3] = 1'b1;
    tick();
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_grant", {28'd0, grant}, 32'd0);
    chk("midrst_outputs", {28'd0, bit_rdy, z, done, aborted}, 32'd0);
    rst = 1'b1;
    req = '0;
    bit_in = '0;
    for (int k = 0; k < 4; k++) tick();

    // two sources held: second winner depends on arbitration mode
`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
    second_id = 1;
`else
    second_id = 3;
`endif
    do_reset();
    req = 4'b1010;
    frame_len = {8'd1, 8'd1, 8'd1, 8'd1};
    exp_q.push_back({1'b0, 2'd1, 8'd0});
    exp_q.push_back({1'b0, 2'(second_id), 8'd0});
    wait_grant("prio1");
    chk("prio_first_grant", {28'd0, grant}, 32'h2);
    wait_done("prio1");
    tick();
    wait_grant("prio2");
    chk("prio_second_grant", {28'd0, grant}, 32'd1 << second_id);
    wait_done("prio2");
    req = '0;
    tick();
    tick();

    // random single-source frames against a bench-side run model
    for (int n = 0; n < 6; n++) begin
      src = $urandom_range(0, 3);
      len = $urandom_range(1, 20);
      pat = $urandom;
      do_frame(src, len, pat, model_hits(pat, len));
      tick();
    end

    for (int k = 0; k < 3; k++) tick();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
